// File: rtl/mbist_pkg.sv
// Shared types for the MBIST fail logger: session states, March Y element
// codes and the default-width fail-entry record.
package mbist_pkg;

  typedef enum logic [1:0] {
    LOG_IDLE = 2'd0,
    LOG_RUN  = 2'd1,
    LOG_DONE = 2'd2
  } log_state_t;

  localparam logic [1:0] ELEM_W0   = 2'd0;  // up(w0)
  localparam logic [1:0] ELEM_R0W1 = 2'd1;  // up(r0,w1,r1)
  localparam logic [1:0] ELEM_R1W0 = 2'd2;  // down(r1,w0,r0)
  localparam logic [1:0] ELEM_R0   = 2'd3;  // up(r0)

  localparam int ENTRY_AW = 6;
  localparam int ENTRY_DW = 8;

  typedef struct packed {
    logic [1:0]          elem;
    logic [ENTRY_AW-1:0] addr;
    logic [ENTRY_DW-1:0] exp;
    logic [ENTRY_DW-1:0] syn;
  } fail_entry_t;

endpackage

// File: rtl/mbist_fail_fifo.sv
// Small synchronous FIFO for fail records; clr empties it in one cycle and
// the head reads zero whenever the FIFO is empty.
module mbist_fail_fifo #(
  parameter  int DEPTH = 4,
  parameter  int EW    = 24,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  input  logic [EW-1:0] din,
  output logic          full,
  output logic [EW-1:0] head,
  output logic [CW-1:0] count
);

  logic [EW-1:0] mem_q [DEPTH];
  logic [EW-1:0] mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          pop_ok, push_ok;

  assign full  = (count_q == CW'(DEPTH));
  assign count = count_q;
  assign head  = (count_q == '0) ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    pop_ok   = pop && (count_q != '0);
    // A pop in the same cycle frees the slot a full-FIFO push needs.
    push_ok  = push && (!full || pop_ok);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop_ok) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries data only; the count gates what is visible.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/mbist_fail_logger.sv
// Diagnostic stage behind the March Y MBIST controller: counts failing reads,
// buffers the first DEPTH failures and reports a pass/fail summary.
module mbist_fail_logger
  import mbist_pkg::*;
#(
  parameter int AW    = 6,
  parameter int DW    = 8,
  parameter int DEPTH = 4,
  parameter int CNTW  = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            cmp_valid,
  input  logic [1:0]      cmp_elem,
  input  logic [AW-1:0]   cmp_addr,
  input  logic [DW-1:0]   cmp_exp,
  input  logic [DW-1:0]   cmp_act,
  input  logic            test_done,
  output logic            log_valid,
  input  logic            log_ready,
  output logic [1:0]      log_elem,
  output logic [AW-1:0]   log_addr,
  output logic [DW-1:0]   log_exp,
  output logic [DW-1:0]   log_syn,
  output logic [CNTW-1:0] fail_count,
  output logic            overflow,
  output logic            busy,
  output logic            done,
  output logic            pass
);

  localparam int EW = 2 + AW + 2 * DW;
  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [1:0]    elem;
    logic [AW-1:0] addr;
    logic [DW-1:0] exp;
    logic [DW-1:0] syn;
  } entry_t;

  log_state_t      state_q, state_d;
  logic [CNTW-1:0] fail_count_q, fail_count_d;
  logic            overflow_q, overflow_d;
  logic            fail, pop, fifo_full;
  logic [CW-1:0]   fifo_count;
  entry_t          push_entry, head_entry;

  // start wins over a same-cycle compare, so that compare never counts.
  assign fail = cmp_valid && (cmp_exp != cmp_act) && (state_q == LOG_RUN) && !start;
  assign pop  = log_valid && log_ready;

  assign push_entry = '{elem: cmp_elem, addr: cmp_addr, exp: cmp_exp, syn: cmp_exp ^ cmp_act};

  mbist_fail_fifo #(
    .DEPTH(DEPTH),
    .EW   (EW)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .clr  (start),
    .push (fail),
    .pop  (pop),
    .din  (push_entry),
    .full (fifo_full),
    .head (head_entry),
    .count(fifo_count)
  );

  always_comb begin
    state_d      = state_q;
    fail_count_d = fail_count_q;
    overflow_d   = overflow_q;
    if (start) begin
      state_d      = LOG_RUN;
      fail_count_d = '0;
      overflow_d   = 1'b0;
    end else begin
      if (state_q == LOG_RUN && test_done) state_d = LOG_DONE;
      if (fail && fail_count_q != '1) fail_count_d = fail_count_q + 1'b1;
      if (fail && fifo_full && !pop) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= LOG_IDLE;
      fail_count_q <= '0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      fail_count_q <= fail_count_d;
      overflow_q   <= overflow_d;
    end
  end

  assign log_valid  = (fifo_count != '0);
  assign log_elem   = head_entry.elem;
  assign log_addr   = head_entry.addr;
  assign log_exp    = head_entry.exp;
  assign log_syn    = head_entry.syn;
  assign fail_count = fail_count_q;
  assign overflow   = overflow_q;
  assign busy       = (state_q == LOG_RUN);
  assign done       = (state_q == LOG_DONE);
  assign pass       = done && (fail_count_q == '0);

endmodule

// File: tb/tb_mbist_fail_logger.sv
// Self-checking bench for mbist_fail_logger: a directed vector table plus
// hand-written sequences for overflow, full push/pop and async reset.
module tb_mbist_fail_logger;
  import mbist_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, cmp_valid = 1'b0, test_done = 1'b0, log_ready = 1'b0;
  logic [1:0] cmp_elem = '0;
  logic [5:0] cmp_addr = '0;
  logic [7:0] cmp_exp = '0, cmp_act = '0;
  logic       log_valid, overflow, busy, done, pass;
  logic [1:0] log_elem;
  logic [5:0] log_addr;
  logic [7:0] log_exp, log_syn, fail_count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mbist_fail_logger #(.AW(6), .DW(8), .DEPTH(4), .CNTW(8)) dut (
    .clk(clk), .rst(rst), .start(start), .cmp_valid(cmp_valid),
    .cmp_elem(cmp_elem), .cmp_addr(cmp_addr), .cmp_exp(cmp_exp),
    .cmp_act(cmp_act), .test_done(test_done), .log_valid(log_valid),
    .log_ready(log_ready), .log_elem(log_elem), .log_addr(log_addr),
    .log_exp(log_exp), .log_syn(log_syn), .fail_count(fail_count),
    .overflow(overflow), .busy(busy), .done(done), .pass(pass)
  );

  typedef struct {
    logic       st, cv;
    logic [1:0] el;
    logic [5:0] ad;
    logic [7:0] ex, ac;
    logic       td, rdy;
    logic       e_lv;
    logic [1:0] e_el;
    logic [5:0] e_ad;
    logic [7:0] e_syn, e_fc;
    logic       e_ov, e_busy, e_done, e_pass;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string nm, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    end
  endtask

  task automatic drive(input logic st, input logic cv, input logic [1:0] el,
                       input logic [5:0] ad, input logic [7:0] ex,
                       input logic [7:0] ac, input logic td, input logic rdy);
    start = st; cmp_valid = cv; cmp_elem = el; cmp_addr = ad;
    cmp_exp = ex; cmp_act = ac; test_done = td; log_ready = rdy;
    @(posedge clk);
    #1;
    start = 1'b0; cmp_valid = 1'b0; test_done = 1'b0; log_ready = 1'b0;
  endtask

  task automatic chk_status(input string nm, input int lv, input int fc,
                            input int ov, input int bs, input int dn, input int ps);
    chk({nm, ".log_valid"}, int'(log_valid), lv);
    chk({nm, ".fail_count"}, int'(fail_count), fc);
    chk({nm, ".overflow"}, int'(overflow), ov);
    chk({nm, ".busy"}, int'(busy), bs);
    chk({nm, ".done"}, int'(done), dn);
    chk({nm, ".pass"}, int'(pass), ps);
  endtask

  initial begin
    //         st    cv    el         ad     ex     ac     td    rdy   lv    el         ad     syn    fc     ov    bsy   dn    ps
    vecs[0]  = '{1'b1, 1'b0, ELEM_W0,   6'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0,      6'h00, 8'h00, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, ELEM_R0W1, 6'h01, 8'hAA, 8'hAA, 1'b0, 1'b0, 1'b0, 2'd0,      6'h00, 8'h00, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, ELEM_W0,   6'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 2'd0,      6'h00, 8'h00, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[3]  = '{1'b0, 1'b1, ELEM_R0,   6'h07, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b0, 2'd0,      6'h00, 8'h00, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[4]  = '{1'b1, 1'b0, ELEM_W0,   6'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0,      6'h00, 8'h00, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, ELEM_R0W1, 6'h05, 8'hFF, 8'hF7, 1'b0, 1'b0, 1'b1, ELEM_R0W1, 6'h05, 8'h08, 8'd1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, ELEM_W0,   6'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, ELEM_R0W1, 6'h05, 8'h08, 8'd1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, ELEM_W0,   6'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, ELEM_R0W1, 6'h05, 8'h08, 8'd1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, ELEM_W0,   6'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 2'd0,      6'h00, 8'h00, 8'd1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, ELEM_R0,   6'h09, 8'h12, 8'h34, 1'b0, 1'b0, 1'b0, 2'd0,      6'h00, 8'h00, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b1, ELEM_R1W0, 6'h0A, 8'h0F, 8'h00, 1'b1, 1'b0, 1'b1, ELEM_R1W0, 6'h0A, 8'h0F, 8'd1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 1'b0, ELEM_W0,   6'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 2'd0,      6'h00, 8'h00, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b1, ELEM_R0,   6'h11, 8'h01, 8'h03, 1'b0, 1'b1, 1'b1, ELEM_R0,   6'h11, 8'h02, 8'd1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b0, ELEM_W0,   6'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 2'd0,      6'h00, 8'h00, 8'd1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 1'b1, ELEM_R0W1, 6'h12, 8'h5A, 8'h5A, 1'b1, 1'b0, 1'b0, 2'd0,      6'h00, 8'h00, 8'd1, 1'b0, 1'b0, 1'b1, 1'b0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_status("reset", 0, 0, 0, 0, 0, 0);
    chk("reset.log_syn", int'(log_syn), 0);
    chk("reset.log_addr", int'(log_addr), 0);
    rst = 1'b0;

    // 16 passing compares then test_done
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++)
      drive(0, 1, ELEM_R0W1, 6'(i), 8'(i * 3), 8'(i * 3), 0, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    chk_status("allpass", 0, 0, 0, 0, 1, 1);

    // Vector table
    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].st, vecs[i].cv, vecs[i].el, vecs[i].ad, vecs[i].ex,
            vecs[i].ac, vecs[i].td, vecs[i].rdy);
      chk_status($sformatf("vec%0d", i), int'(vecs[i].e_lv), int'(vecs[i].e_fc),
                 int'(vecs[i].e_ov), int'(vecs[i].e_busy), int'(vecs[i].e_done),
                 int'(vecs[i].e_pass));
      chk($sformatf("vec%0d.log_elem", i), int'(log_elem), int'(vecs[i].e_el));
      chk($sformatf("vec%0d.log_addr", i), int'(log_addr), int'(vecs[i].e_ad));
      chk($sformatf("vec%0d.log_syn", i), int'(log_syn), int'(vecs[i].e_syn));
    end

    // Six fails into a 4-deep FIFO, then drain
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++)
      drive(0, 1, ELEM_R1W0, 6'(8'h20 + i), 8'h00, 8'h01, 0, 0);
    chk_status("ovf", 1, 6, 1, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("ovf.drain%0d.valid", i), int'(log_valid), 1);
      chk($sformatf("ovf.drain%0d.addr", i), int'(log_addr), 8'h20 + i);
      drive(0, 0, 0, 0, 0, 0, 0, 1);
    end
    chk("ovf.empty", int'(log_valid), 0);

    // Full FIFO, fail with same-cycle pop
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++)
      drive(0, 1, ELEM_R0, 6'(8'h30 + i), 8'hF0, 8'h0F, 0, 0);
    chk("full.ovf_before", int'(overflow), 0);
    drive(0, 1, ELEM_R0, 6'h34, 8'hF0, 8'h0F, 0, 1);
    chk_status("fullpp", 1, 5, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("fullpp.drain%0d.valid", i), int'(log_valid), 1);
      chk($sformatf("fullpp.drain%0d.addr", i), int'(log_addr), 8'h31 + i);
      drive(0, 0, 0, 0, 0, 0, 0, 1);
    end
    chk("fullpp.empty", int'(log_valid), 0);

    // Async reset mid-session with 3 entries queued
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      drive(0, 1, ELEM_R0W1, 6'(8'h3A + i), 8'h80, 8'h00, 0, 0);
    chk("prerst.fail_count", int'(fail_count), 3);
    #2 rst = 1'b1;
    #1;
    chk_status("rst", 0, 0, 0, 0, 0, 0);
    chk("rst.log_addr", int'(log_addr), 0);
    chk("rst.log_syn", int'(log_syn), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    chk_status("postrst", 0, 0, 0, 1, 0, 0);
    drive(0, 1, ELEM_R0, 6'h02, 8'hC3, 8'hC1, 0, 0);
    chk_status("postrst.fail", 1, 1, 0, 1, 0, 0);
    chk("postrst.log_addr", int'(log_addr), 2);
    chk("postrst.log_exp", int'(log_exp), 8'hC3);
    chk("postrst.log_syn", int'(log_syn), 8'h02);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mbist_fail_logger.md
# mbist_fail_logger

Downstream diagnostic stage for the March Y MBIST controller (`controller1`). The controller only reports a single pass/fail `status`. This block consumes the controller's per-read compare stream. It counts failing reads and buffers the first `DEPTH` failures (March element, address, expected and actual data) in a small FIFO. A host or scan collector drains the FIFO through a valid/ready port and reads a pass/fail summary.

## Interface
Parameters:
- `AW`, 6, compare address width; equals the controller's CAWIDTH+RAWIDTH.
- `DW`, 8, data width; matches the controller `dataout`.
- `DEPTH`, 4, fail-FIFO entries; power of two, ≥2.
- `CNTW`, 8, fail-counter width.

Ports:
- `clk`  in  1  single clock; all state is on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse: clear all logs and begin a session.
- `cmp_valid`  in  1  the controller performed a read compare this cycle.
- `cmp_elem`  in  2  March Y element of that read (0..3).
- `cmp_addr`  in  AW  address of that read.
- `cmp_exp`  in  DW  expected data.
- `cmp_act`  in  DW  data read from memory.
- `test_done`  in  1  one-cycle pulse: controller finished (its Test fell).
- `log_valid`  out  1  the FIFO head entry is presented.
- `log_ready`  in  1  the consumer accepts the head entry.
- `log_elem`  out  2  head entry element.
- `log_addr`  out  AW  head entry address.
- `log_exp`  out  DW  head entry expected data.
- `log_syn`  out  DW  head entry syndrome (exp XOR act).
- `fail_count`  out  CNTW  failing compares this session; saturates.
- `overflow`  out  1  sticky: a failure arrived while the FIFO was full.
- `busy`  out  1  state is LOG.
- `done`  out  1  state is DONE.
- `pass`  out  1  `done` and `fail_count == 0`.

## Operation
- States are IDLE, LOG and DONE. Reset enters IDLE.
- `start` moves any state to LOG. It also clears the FIFO, `fail_count` and `overflow`.
- In LOG, `test_done` moves the block to DONE. DONE holds until the next `start`.
- A fail is `cmp_valid && (cmp_exp != cmp_act)` while in LOG. Compares outside LOG are ignored.
- On each fail, `fail_count` increments, saturating at 2^CNTW−1.
- On each fail, the entry {elem, addr, exp, exp^act} is pushed if the FIFO is not full.
  - If the FIFO is full and no pop occurs that cycle, the entry is dropped and `overflow` is set.
- Pop occurs when `log_valid && log_ready`. Pop is legal in LOG and DONE, and in IDLE until the FIFO is empty.
- Element encoding:
  - 0 = ⇑w0
  - 1 = ⇑(r0,w1,r1)
  - 2 = ⇓(r1,w0,r0)
  - 3 = ⇑r0

## Timing
- Reset value of every output is 0. `log_*` data outputs read 0 when the FIFO is empty.
- A fail compare in cycle N:
  - `fail_count` updates at N+1.
  - With the FIFO empty, `log_valid` rises at N+1 and `log_*` is valid the same cycle.
- A `test_done` in cycle N gives `done`/`pass` high at N+1. A fail in the same cycle N is still logged and counted.
- `start` and `cmp_valid` in the same cycle: `start` wins, the compare is dropped, and the block is in LOG with empty logs at N+1.
- `start` and `test_done` in the same cycle: `start` wins.
- Push and pop in the same cycle on a full FIFO: the pop frees the slot, the push succeeds, occupancy is unchanged and `overflow` is not set.
- Push and pop in the same cycle on an empty FIFO: no pop occurs. The push lands and `log_valid` rises next cycle.
- The head entry is stable while `log_valid && !log_ready`.
- An asynchronous `rst` mid-session clears everything immediately. Entries are lost.
- Pointers are log2(DEPTH) bits wide and wrap modulo DEPTH. A separate count register of log2(DEPTH)+1 bits distinguishes full from empty.

## Structure
- Package `mbist_pkg` holds:
  - the state enum (`LOG_IDLE`, `LOG_RUN`, `LOG_DONE`);
  - the element encoding constants `ELEM_W0`..`ELEM_R0`;
  - the packed fail-entry struct {elem, addr, exp, syn}, sized from AW/DW.
- Sub-module `mbist_fail_fifo` is a synchronous FIFO. It has the parameters DEPTH and the entry width, a `clr` input, push/pop, a full/empty indication, a head output and the count.
- The top level owns the FSM, fail detection, the saturating counter and the overflow flag.

## Test plan
- Reset, then `start`, then 16 passing compares, then `test_done` → `done=1`, `pass=1`, `fail_count=0`, `log_valid=0`.
- One fail, elem 1, addr 0x05, exp 0xFF, act 0xF7 → `log_valid` rises next cycle with `log_syn=0x08`. `fail_count=1`. `pass=0` after `test_done`.
- Six fails with `log_ready=0` → `fail_count=6`, `overflow=1`. Draining yields exactly the first four addresses in order.
- With the FIFO full, a fail and `log_ready=1` in the same cycle → occupancy stays 4, `overflow=0`, and the new entry is last out.
- `start` with a fail in the same cycle, and separately a fail with `test_done` in the same cycle → the first is dropped (`fail_count=0`). The second is counted, and `done` rises next cycle.
- `rst` asserted mid-session with 3 entries queued → all outputs 0 immediately. The next `start` gives a clean session.
